idelay_scan_ctrl: RTL and testbench

Read-capture calibration sequencer for one DQ bit lane. The lane is an IDELAY followed by a 4:1 DDR memory-mode ISERDES.
- Sweeps the IDELAY tap over the full range.
- At each tap, samples the 4-bit deserialized word and compares it against a known training pattern.
- Finds the longest contiguous passing window and loads the tap at its centre.
- Sits between the PHY training FSM (start/pattern) and the per-bit IDELAY load interface.

---
 rtl/idelay_scan_if.sv | 28 ++
 rtl/idelay_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_idelay_scan_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/idelay_scan_if.sv
// Signal bundle between the PHY training FSM / IDELAY lane and the read-capture scan controller.
interface idelay_scan_if #(
    parameter int TAP_WIDTH = 5
);
    // start is a one-cycle request accepted only when busy=0 and no done pulse is present;
    // done is a one-cycle completion pulse and the results are valid from that cycle on.
    logic                 start;
    logic [3:0]           pattern;
    logic [3:0]           dout;
    logic [TAP_WIDTH-1:0] dly_tap;
    logic                 dly_ld;
    logic                 busy;
    logic                 done;
    logic                 fail;
    logic [TAP_WIDTH-1:0] win_first;
    logic [TAP_WIDTH:0]   win_len;
    logic [2:0]           fsm_state;

    modport master (
        output start, pattern, dout,
        input  dly_tap, dly_ld, busy, done, fail, win_first, win_len, fsm_state
    );

    modport slave (
        input  start, pattern, dout,
        output dly_tap, dly_ld, busy, done, fail, win_first, win_len, fsm_state
    );
endinterface

// File: rtl/idelay_scan_ctrl.sv
// IDELAY tap sweep for one DQ lane: scores each tap against a training pattern and
// loads the centre of the longest contiguous passing window.
module idelay_scan_ctrl #(
    parameter int TAP_WIDTH     = 5,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int ERR_LIMIT     = 0
) (
    input  logic clk,
    input  logic rst_n,
    idelay_scan_if.slave bus
);
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ERR_W   = $clog2(SAMPLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     FINAL_LAST  = CNT_W'(SETTLE_CYCLES);
    localparam logic [TAP_WIDTH-1:0] TAP_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_CENTER, S_FINAL, S_DONE
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [ERR_W-1:0]     err_cnt;
    logic [TAP_WIDTH-1:0] tap;
    logic [TAP_WIDTH-1:0] run_first;
    logic [TAP_WIDTH:0]   run_len;
    logic [TAP_WIDTH-1:0] best_first;
    logic [TAP_WIDTH:0]   best_len;
    logic [TAP_WIDTH-1:0] dly_tap_q;
    logic                 dly_ld_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 fail_q;
    logic [TAP_WIDTH-1:0] win_first_q;
    logic [TAP_WIDTH:0]   win_len_q;

    logic                 pass;
    logic [TAP_WIDTH-1:0] cand_first;
    logic [TAP_WIDTH:0]   cand_len;
    logic [TAP_WIDTH:0]   half_len;
    logic [TAP_WIDTH-1:0] center_tap;

    // Candidate run includes the tap under evaluation; a fresh run starts at this tap.
    always_comb begin
        pass       = ($unsigned(32'(err_cnt)) <= $unsigned(32'(ERR_LIMIT)));
        cand_first = (run_len == '0) ? tap : run_first;
        cand_len   = run_len + 1'b1;
        half_len   = (best_len - 1'b1) >> 1;
        center_tap = best_first + half_len[TAP_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            err_cnt     <= '0;
            tap         <= '0;
            run_first   <= '0;
            run_len     <= '0;
            best_first  <= '0;
            best_len    <= '0;
            dly_tap_q   <= '0;
            dly_ld_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            win_first_q <= '0;
            win_len_q   <= '0;
        end else begin
            dly_ld_q <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        tap        <= '0;
                        run_first  <= '0;
                        run_len    <= '0;
                        best_first <= '0;
                        best_len   <= '0;
                        err_cnt    <= '0;
                        cnt        <= '0;
                        fail_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        dly_tap_q  <= '0;
                        dly_ld_q   <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if ((bus.dout != bus.pattern) && (err_cnt != '1))
                        err_cnt <= err_cnt + 1'b1;
                    if (cnt == SAMPLE_LAST) begin
                        cnt   <= '0;
                        state <= S_EVAL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EVAL: begin
                    if (pass) begin
                        run_first <= cand_first;
                        run_len   <= cand_len;
                        // Strictly longer only, so the earliest of equal windows is kept.
                        if (cand_len > best_len) begin
                            best_first <= cand_first;
                            best_len   <= cand_len;
                        end
                    end else begin
                        run_len <= '0;
                    end
                    err_cnt <= '0;
                    if (tap == TAP_MAX) begin
                        state <= S_CENTER;
                    end else begin
                        tap       <= tap + 1'b1;
                        dly_tap_q <= tap + 1'b1;
                        dly_ld_q  <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_CENTER: begin
                    win_first_q <= best_first;
                    win_len_q   <= best_len;
                    if (best_len != '0) begin
                        tap       <= center_tap;
                        dly_tap_q <= center_tap;
                    end else begin
                        tap       <= '0;
                        dly_tap_q <= '0;
                        fail_q    <= 1'b1;
                    end
                    dly_ld_q <= 1'b1;
                    cnt      <= '0;
                    state    <= S_FINAL;
                end
                S_FINAL: begin
                    // Load cycle (cnt=0) followed by the settle interval.
                    if (cnt == FINAL_LAST) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dly_tap   = dly_tap_q;
    assign bus.dly_ld    = dly_ld_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fail      = fail_q;
    assign bus.win_first = win_first_q;
    assign bus.win_len   = win_len_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_idelay_scan_ctrl.sv
// Bench for idelay_scan_ctrl: two instances (ERR_LIMIT 0 and 1) share one modelled DQ lane;
// expected scan results are queued at start and checked when done pulses.
module tb_idelay_scan_ctrl;
    localparam int W = 17;  // {win_first[4:0], win_len[5:0], dly_tap[4:0], fail}

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] dout;

    always #5 clk = ~clk;

    idelay_scan_if #(.TAP_WIDTH(5)) bus0 ();
    idelay_scan_if #(.TAP_WIDTH(5)) bus1 ();

    assign bus0.start   = start;
    assign bus0.pattern = pattern;
    assign bus0.dout    = dout;
    assign bus1.start   = start;
    assign bus1.pattern = pattern;
    assign bus1.dout    = dout;

    idelay_scan_ctrl #(.TAP_WIDTH(5), .SETTLE_CYCLES(8), .SAMPLE_CYCLES(16), .ERR_LIMIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    idelay_scan_ctrl #(.TAP_WIDTH(5), .SETTLE_CYCLES(8), .SAMPLE_CYCLES(16), .ERR_LIMIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ex(input int wf, input int wl, input int tp, input int f);
        return {5'(wf), 6'(wl), 5'(tp), 1'(f)};
    endfunction

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Lane model: each tap passes or fails as a whole, with an optional one-cycle flip
    // at a given phase after the tap load (0 = load, 1..8 settle, 9..24 sample).
    logic [31:0] pass_mask = '0;
    int inj_tap = -1;
    int inj_phase = -1;
    int cur_tap = 0;
    int phase = 0;

    always @(negedge clk) begin
        if (bus0.dly_ld) begin
            cur_tap = int'(bus0.dly_tap);
            phase = 0;
        end else begin
            phase = phase + 1;
        end
        dout = pass_mask[cur_tap] ? pattern : ~pattern;
        if (cur_tap == inj_tap && phase == inj_phase) dout = ~dout;
    end

    // Monitor: counts load strobes and busy cycles, pops expectations on each done.
    logic prev_busy = 1'b0;
    int   cyc = 0;
    int   ld_cnt = 0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            cyc = 0;
            ld_cnt = 0;
        end else begin
            if (bus0.busy && !prev_busy) begin
                cyc = 1;
                ld_cnt = 0;
            end else if (bus0.busy || bus0.done) begin
                cyc++;
            end
            if (bus0.dly_ld) ld_cnt++;
            if (bus0.done) begin
                if (exp_q0.size() == 0) begin
                    check("unexpected_done0", 1, 0);
                end else begin
                    e = exp_q0.pop_front();
                    check("win_first0", int'(bus0.win_first), int'(e[16:12]));
                    check("win_len0", int'(bus0.win_len), int'(e[11:6]));
                    check("dly_tap0", int'(bus0.dly_tap), int'(e[5:1]));
                    check("fail0", int'(bus0.fail), int'(e[0]));
                    check("busy_cycles", cyc, 843);
                    check("ld_pulses", ld_cnt, 33);
                end
            end
            if (bus1.done) begin
                if (exp_q1.size() == 0) begin
                    check("unexpected_done1", 1, 0);
                end else begin
                    e = exp_q1.pop_front();
                    check("win_first1", int'(bus1.win_first), int'(e[16:12]));
                    check("win_len1", int'(bus1.win_len), int'(e[11:6]));
                    check("dly_tap1", int'(bus1.dly_tap), int'(e[5:1]));
                    check("fail1", int'(bus1.fail), int'(e[0]));
                end
            end
        end
        prev_busy = bus0.busy;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_dly_tap"}, int'(bus0.dly_tap) + int'(bus1.dly_tap), 0);
        check({tag, "_dly_ld"}, int'(bus0.dly_ld) + int'(bus1.dly_ld), 0);
        check({tag, "_busy"}, int'(bus0.busy) + int'(bus1.busy), 0);
        check({tag, "_done"}, int'(bus0.done) + int'(bus1.done), 0);
        check({tag, "_fail"}, int'(bus0.fail) + int'(bus1.fail), 0);
        check({tag, "_win_first"}, int'(bus0.win_first) + int'(bus1.win_first), 0);
        check({tag, "_win_len"}, int'(bus0.win_len) + int'(bus1.win_len), 0);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_scan(input logic [31:0] mask, input logic [3:0] pat, input int itap,
                            input int iphase, input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input bit repulse);
        bit got = 0;
        pass_mask = mask;
        pattern = pat;
        inj_tap = itap;
        inj_phase = iphase;
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
        pulse_start();
        check("busy_after_start", int'(bus0.busy), 1);
        check("fail_cleared", int'(bus0.fail), 0);
        if (repulse) begin
            repeat (300) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        for (int i = 0; i < 1500 && !got; i++) begin
            @(posedge clk);
            #1 if (bus0.done) got = 1;
        end
        check("done_seen", int'(got), 1);
        // start during the done cycle must be ignored
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_done", int'(bus0.busy), 0);
        check("tap_held_idle", int'(bus0.dly_tap), int'(e0[5:1]));
    endtask

    initial begin
        bit hit = 0;
        rst_n = 1'b0;
        start = 1'b0;
        pattern = 4'h0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;

        run_scan(rng(10, 19), 4'hA, -1, -1, ex(10, 10, 14, 0), ex(10, 10, 14, 0), 0);
        run_scan(rng(3, 6) | rng(20, 27), 4'h5, -1, -1, ex(20, 8, 23, 0), ex(20, 8, 23, 0), 0);
        run_scan(rng(2, 5) | rng(12, 15), 4'h3, -1, -1, ex(2, 4, 3, 0), ex(2, 4, 3, 0), 0);
        run_scan(rng(25, 31), 4'hC, -1, -1, ex(25, 7, 28, 0), ex(25, 7, 28, 0), 0);
        run_scan(32'hFFFF_FFFF, 4'h9, -1, -1, ex(0, 32, 15, 0), ex(0, 32, 15, 0), 0);
        run_scan(32'h0, 4'h6, -1, -1, ex(0, 0, 0, 1), ex(0, 0, 0, 1), 0);
        run_scan(rng(10, 19), 4'hE, -1, -1, ex(10, 10, 14, 0), ex(10, 10, 14, 0), 1);
        run_scan(rng(8, 12), 4'h1, 10, 12, ex(8, 2, 8, 0), ex(8, 5, 10, 0), 0);
        run_scan(rng(8, 12), 4'h7, 10, 4, ex(8, 5, 10, 0), ex(8, 5, 10, 0), 0);

        // Abort mid-scan at tap 17
        pass_mask = rng(10, 19);
        pattern = 4'hB;
        inj_tap = -1;
        inj_phase = -1;
        pulse_start();
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(posedge clk);
            #1 if (bus0.dly_ld && bus0.dly_tap == 5'd17) hit = 1;
        end
        check("reached_tap17", int'(hit), 1);
        rst_n = 1'b0;
        #1 check_reset_vals("abort");
        repeat (3) @(posedge clk);
        #1 check_reset_vals("abort_hold");
        @(negedge clk) rst_n = 1'b1;

        run_scan(rng(3, 6) | rng(20, 27), 4'h2, -1, -1, ex(20, 8, 23, 0), ex(20, 8, 23, 0), 0);

        repeat (5) @(posedge clk);
        check("queue0_empty", exp_q0.size(), 0);
        check("queue1_empty", exp_q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
